// File: rtl/stopwatch_counter.sv
// stopwatch_counter: count-up m:ss BCD stopwatch (0:00 .. MAX_MINS:59) with an overflow flag.
// Optional macro LAP_HOLD_EN builds the lap-hold display freeze; without it lap is ignored.
module stopwatch_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int MAX_MINS = 9
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] secs,
    output logic [3:0] ten_secs,
    output logic [3:0] mins,
    output logic       running,
    output logic       tick,
    output logic       overflow,
    output logic       lap_active
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [3:0]    MAX_M      = 4'(MAX_MINS);
    localparam logic [11:0]   COUNT_MAX  = {MAX_M, 4'd5, 4'd9};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_OVERFLOW = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;
    logic [11:0]   count_r;      // live count {mins, ten_secs, secs}
    logic [11:0]   count_s;
    logic [11:0]   disp_r;
    logic [11:0]   disp_s;
    logic          adv_s;
    logic          terminal_s;
    logic          at_max_s;
    logic          running_r;
    logic          running_s;
    logic          tick_r;
    logic          tick_s;
    logic          overflow_r;
    logic          overflow_s;
    logic          lap_active_r;
    logic          lap_active_s;

    // Advance a packed m:ss BCD value by one second, digit by digit.
    function automatic logic [11:0] bcd_advance(input logic [11:0] c);
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] s;
        m = c[11:8];
        t = c[7:4];
        s = c[3:0];
        if (s != 4'd9) begin
            s = s + 4'd1;
        end else if (t != 4'd5) begin
            s = 4'd0;
            t = t + 4'd1;
        end else begin
            s = 4'd0;
            t = 4'd0;
            m = m + 4'd1;
        end
        return {m, t, s};
    endfunction

    assign terminal_s = (presc_r == PRESC_LAST);
    assign at_max_s   = (count_r == COUNT_MAX);

    // State, prescaler and live count registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= ST_IDLE;
            presc_r <= PRESC_ZERO;
            count_r <= 12'd0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            count_r <= count_s;
        end
    end

    // Next state: clear beats start_stop; a terminal tick is applied before a pause takes effect.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        count_s = count_r;
        adv_s   = 1'b0;
        if (clear) begin
            state_s = ST_IDLE;
            presc_s = PRESC_ZERO;
            count_s = 12'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_stop) begin
                        state_s = ST_RUNNING;
                        presc_s = PRESC_ZERO;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (terminal_s) begin
                        adv_s   = 1'b1;
                        presc_s = PRESC_ZERO;
                        if (at_max_s) begin
                            state_s = ST_OVERFLOW;
                            count_s = COUNT_MAX;
                        end else begin
                            count_s = bcd_advance(count_r);
                            state_s = start_stop ? ST_PAUSED : ST_RUNNING;
                        end
                    end else if (start_stop) begin
                        // Pausing keeps the partial second in the prescaler.
                        state_s = ST_PAUSED;
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                end
                ST_PAUSED: begin
                    if (start_stop) begin
                        state_s = ST_RUNNING;
                    end else begin
                        state_s = ST_PAUSED;
                    end
                end
                ST_OVERFLOW: begin
                    state_s = ST_OVERFLOW;
                    count_s = COUNT_MAX;
                end
                default: begin
                    state_s = ST_IDLE;
                    presc_s = PRESC_ZERO;
                    count_s = 12'd0;
                end
            endcase
        end
    end

    // Next values of the flag outputs, decoded from the next state.
    always_comb begin
        tick_s     = adv_s;
        running_s  = (state_s == ST_RUNNING);
        overflow_s = (state_s == ST_OVERFLOW);
    end

`ifdef LAP_HOLD_EN
    logic [11:0] hold_r;
    logic [11:0] hold_s;

    // Lap hold: first lap while running freezes the display, second lap releases it.
    always_comb begin
        hold_s       = hold_r;
        lap_active_s = lap_active_r;
        if (clear || (state_s == ST_OVERFLOW)) begin
            lap_active_s = 1'b0;
        end else if (lap && lap_active_r &&
                     ((state_r == ST_RUNNING) || (state_r == ST_PAUSED))) begin
            lap_active_s = 1'b0;
        end else if (lap && !lap_active_r && (state_r == ST_RUNNING)) begin
            lap_active_s = 1'b1;
            hold_s       = count_r;
        end else begin
            lap_active_s = lap_active_r;
        end
    end

    // Held lap value register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            hold_r <= 12'd0;
        end else begin
            hold_r <= hold_s;
        end
    end

    assign disp_s = lap_active_s ? hold_s : count_s;
`else
    logic unused_lap_s;
    assign unused_lap_s = lap;
    assign lap_active_s = 1'b0;
    assign disp_s       = count_s;
`endif

    // Output registers: display digits and status flags.
    always_ff @(posedge CLK) begin
        if (reset) begin
            disp_r       <= 12'd0;
            running_r    <= 1'b0;
            tick_r       <= 1'b0;
            overflow_r   <= 1'b0;
            lap_active_r <= 1'b0;
        end else begin
            disp_r       <= disp_s;
            running_r    <= running_s;
            tick_r       <= tick_s;
            overflow_r   <= overflow_s;
            lap_active_r <= lap_active_s;
        end
    end

    assign mins       = disp_r[11:8];
    assign ten_secs   = disp_r[7:4];
    assign secs       = disp_r[3:0];
    assign running    = running_r;
    assign tick       = tick_r;
    assign overflow   = overflow_r;
    assign lap_active = lap_active_r;

endmodule
